// File: rtl/controle_giro_if.sv
// Request/feedback bundle between the path planner, controle_giro and the
// heading tracker. The master side is the environment (planner + tracker).
// The slave side is the turn-command initiator.
interface controle_giro_if;
  logic [2:0] alvo;
  logic       alvo_valido;
  logic       alvo_pronto;
  logic [2:0] orientacao;
  logic       girar;
  logic       ocupado;
  logic       concluido;
  logic       erro;
  logic [1:0] giros_feitos;

  modport master (
    output alvo, alvo_valido, orientacao,
    input  alvo_pronto, girar, ocupado, concluido, erro, giros_feitos
  );

  modport slave (
    input  alvo, alvo_valido, orientacao,
    output alvo_pronto, girar, ocupado, concluido, erro, giros_feitos
  );
endinterface

// File: rtl/controle_giro.sv
// controle_giro: accepts a target heading and steps the heading tracker
// toward it with single-cycle girar pulses. Each step is confirmed against
// the tracker feedback before the next pulse is issued.
//
// Heading codes: Norte=001, Oeste=010, Leste=011, Sul=100.
// Turn order:    Norte -> Oeste -> Sul -> Leste -> Norte (index 0..3).
module controle_giro #(
  parameter int SETTLE_CYCLES = 2,  // idle cycles between a confirmed turn and the next pulse (1..15)
  parameter int TIMEOUT       = 8   // max ESPERA cycles waiting for feedback (2..15)
) (
  input logic           clockc3,
  input logic           reset,      // asynchronous, active low
  controle_giro_if.slave bus
);

  localparam logic [2:0] H_NORTE = 3'b001;
  localparam logic [2:0] H_OESTE = 3'b010;
  localparam logic [2:0] H_LESTE = 3'b011;
  localparam logic [2:0] H_SUL   = 3'b100;

  localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PULSO   = 3'd1,
    ESPERA  = 3'd2,
    ASSENTA = 3'd3,
    FIM     = 3'd4,
    ERRO    = 3'd5
  } estado_t;

  // Position of a heading in the turn order.
  function automatic logic [1:0] idx(input logic [2:0] h);
    case (h)
      H_NORTE: return 2'd0;
      H_OESTE: return 2'd1;
      H_SUL:   return 2'd2;
      H_LESTE: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Heading reached after one turn from h.
  function automatic logic [2:0] succ(input logic [2:0] h);
    case (h)
      H_NORTE: return H_OESTE;
      H_OESTE: return H_SUL;
      H_SUL:   return H_LESTE;
      H_LESTE: return H_NORTE;
      default: return h;
    endcase
  endfunction

  function automatic logic legal(input logic [2:0] h);
    return (h == H_NORTE) || (h == H_OESTE) || (h == H_SUL) || (h == H_LESTE);
  endfunction

  estado_t    state, state_next;
  logic [3:0] cnt, cnt_next;             // ESPERA timeout / ASSENTA settle counter
  logic [1:0] restante, restante_next;   // turns still to be confirmed
  logic [2:0] esperado, esperado_next;   // heading expected after the current pulse
  logic [2:0] anterior, anterior_next;   // heading seen during the pulse
  logic [1:0] giros, giros_next;
  logic       erro_q, erro_next;
  logic       girar_q, girar_next;
  logic [1:0] needed;

  // Turns needed: distance in the cyclic order, wraps naturally in 2 bits.
  assign needed = idx(bus.alvo) - idx(bus.orientacao);

  // State and datapath registers; async reset clears everything including girar.
  always_ff @(posedge clockc3 or negedge reset) begin
    if (!reset) begin
      state    <= OCIOSO;
      cnt      <= 4'd0;
      restante <= 2'd0;
      esperado <= H_NORTE;
      anterior <= H_NORTE;
      giros    <= 2'd0;
      erro_q   <= 1'b0;
      girar_q  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      restante <= restante_next;
      esperado <= esperado_next;
      anterior <= anterior_next;
      giros    <= giros_next;
      erro_q   <= erro_next;
      girar_q  <= girar_next;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt + 4'd1;
    restante_next = restante;
    esperado_next = esperado;
    anterior_next = anterior;
    giros_next    = giros;
    erro_next     = erro_q;

    case (state)
      OCIOSO: begin
        if (bus.alvo_valido) begin
          erro_next  = 1'b0;
          giros_next = 2'd0;
          if (!legal(bus.alvo) || !legal(bus.orientacao)) begin
            state_next = ERRO;
          end else if (needed == 2'd0) begin
            state_next = FIM;
          end else begin
            restante_next = needed;
            state_next    = PULSO;
          end
        end
      end
      PULSO: begin
        // Tracker has not moved yet: this is the pre-pulse heading.
        esperado_next = succ(bus.orientacao);
        anterior_next = bus.orientacao;
        cnt_next      = 4'd0;
        state_next    = ESPERA;
      end
      ESPERA: begin
        if (bus.orientacao == esperado) begin
          giros_next    = giros + 2'd1;
          restante_next = restante - 2'd1;
          cnt_next      = 4'd0;
          state_next    = (restante == 2'd1) ? FIM : ASSENTA;
        end else if (bus.orientacao != anterior) begin
          state_next = ERRO;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = ERRO;
        end
      end
      ASSENTA: begin
        if (cnt == SETTLE_LAST) begin
          state_next = PULSO;
        end
      end
      FIM:     state_next = OCIOSO;
      ERRO:    state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase

    // erro rises together with the ERRO state and holds until the next request.
    if (state_next == ERRO) begin
      erro_next = 1'b1;
    end
  end

  // girar comes straight from a flop that is high exactly in PULSO.
  always_comb begin
    girar_next = (state_next == PULSO);
  end

  assign bus.girar        = girar_q;
  assign bus.alvo_pronto  = (state == OCIOSO);
  assign bus.ocupado      = (state != OCIOSO);
  assign bus.concluido    = (state == FIM);
  assign bus.erro         = erro_q;
  assign bus.giros_feitos = giros;

endmodule

// File: tb/tb_controle_giro.sv
// Directed bench for controle_giro with a behavioural heading tracker and a
// scoreboard of expected request outcomes.
module tb_controle_giro;

  localparam int SETTLE = 2;
  localparam int TMO    = 8;

  localparam logic [2:0] HN = 3'b001;
  localparam logic [2:0] HO = 3'b010;
  localparam logic [2:0] HL = 3'b011;
  localparam logic [2:0] HS = 3'b100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  controle_giro_if bus();

  controle_giro #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
    .clockc3 (clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pulsos;
    logic [1:0] giros;
    logic       ok;
    logic       err;
    logic [2:0] final_h;
    int         lat;     // cycles from the first post-handshake cycle to concluido/erro
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cycle_n = 0;
  bit   frozen  = 1'b0;

  function automatic logic [2:0] succ_h(input logic [2:0] h);
    case (h)
      HN: return HO;
      HO: return HS;
      HS: return HL;
      HL: return HN;
      default: return h;
    endcase
  endfunction

  function automatic bit legal_h(input logic [2:0] h);
    return (h == HN) || (h == HO) || (h == HS) || (h == HL);
  endfunction

  // Reference outcome of one request, found by walking the turn order.
  function automatic exp_t model(input logic [2:0] a, input logic [2:0] o, input bit fr);
    exp_t e;
    int k;
    logic [2:0] h;
    e.final_h = o;
    e.pulsos  = 0;
    e.giros   = 2'd0;
    e.ok      = 1'b0;
    e.err     = 1'b0;
    e.lat     = 0;
    if (!legal_h(a) || !legal_h(o)) begin
      e.err = 1'b1;
      return e;
    end
    k = 0;
    h = o;
    while (h != a && k < 4) begin
      h = succ_h(h);
      k++;
    end
    if (k == 0) begin
      e.ok = 1'b1;
    end else if (fr) begin
      e.pulsos = 1;
      e.err    = 1'b1;
      e.lat    = 1 + TMO;
    end else begin
      e.pulsos  = k;
      e.giros   = 2'(k);
      e.ok      = 1'b1;
      e.final_h = a;
      e.lat     = 2 + (k - 1) * (2 + SETTLE);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the tracker steps on the edge that ends a girar cycle.
  task automatic cyc();
    logic g;
    g = bus.girar;
    @(posedge clk);
    #1;
    cycle_n++;
    if (g === 1'b1 && !frozen) bus.orientacao = succ_h(bus.orientacao);
  endtask

  // Issue a request and compare its outcome with the scoreboard head.
  task automatic do_req(input logic [2:0] a, input logic [2:0] o, input bit fr, input int hold);
    exp_t e;
    int   hs, last, pulses;
    bit   done;
    frozen          = fr;
    bus.orientacao  = o;
    bus.alvo        = a;
    bus.alvo_valido = 1'b1;
    check("pronto_idle", bus.alvo_pronto, 1);
    sb.push_back(model(a, o, fr));
    cyc();
    hs = cycle_n;
    if (hold == 0) bus.alvo_valido = 1'b0;
    else           bus.alvo = HL;
    if (legal_h(a) && legal_h(o)) check("erro_cleared", bus.erro, 0);
    pulses = 0;
    last   = -1;
    done   = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (hold != 0 && i == 1) check("pronto_busy", bus.alvo_pronto, 0);
      if (hold != 0 && i == hold) bus.alvo_valido = 1'b0;
      if (bus.girar === 1'b1) begin
        if (last >= 0) check("pulse_spacing", cycle_n - last, 2 + SETTLE);
        pulses++;
        last = cycle_n;
      end
      if (bus.concluido === 1'b1 || bus.erro === 1'b1) done = 1'b1;
      else cyc();
    end
    bus.alvo_valido = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL req_timeout: observed no completion expected concluido or erro");
    end
    e = sb.pop_front();
    check("latency",      cycle_n - hs, e.lat);
    check("pulses",       pulses, e.pulsos);
    check("giros_feitos", bus.giros_feitos, e.giros);
    check("concluido",    bus.concluido, e.ok);
    check("erro",         bus.erro, e.err);
    check("heading",      bus.orientacao, e.final_h);
    $display("[TB] req alvo=%b from=%b: pulses=%0d giros=%0d concluido=%b erro=%b lat=%0d",
             a, o, pulses, bus.giros_feitos, bus.concluido, bus.erro, cycle_n - hs);
    cyc();
    check("idle_ocupado",   bus.ocupado, 0);
    check("idle_pronto",    bus.alvo_pronto, 1);
    check("idle_concluido", bus.concluido, 0);
    check("idle_girar",     bus.girar, 0);
    check("erro_sticky",    bus.erro, e.err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alvo        = HN;
    bus.alvo_valido = 1'b0;
    bus.orientacao  = HN;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_girar",     bus.girar, 0);
    check("rst_ocupado",   bus.ocupado, 0);
    check("rst_concluido", bus.concluido, 0);
    check("rst_erro",      bus.erro, 0);
    check("rst_giros",     bus.giros_feitos, 0);
    check("rst_pronto",    bus.alvo_pronto, 1);
    rst_n = 1'b1;
    cyc();

    do_req(HS, HN, 1'b0, 3);      // two turns, valid held while busy is ignored
    do_req(HS, HL, 1'b0, 0);      // three turns wrapping through Norte
    do_req(HO, HO, 1'b0, 0);      // already on target
    do_req(HO, HN, 1'b1, 0);      // tracker frozen: timeout
    do_req(HO, HN, 1'b0, 0);      // new request clears erro
    do_req(3'b111, HN, 1'b0, 0);  // illegal target
    do_req(HN, 3'b000, 1'b0, 0);  // illegal feedback
    do_req(HL, HS, 1'b0, 0);      // single step after an error

    // Reset in the second PULSO of a request, after one confirmed turn.
    frozen          = 1'b0;
    bus.orientacao  = HN;
    bus.alvo        = HS;
    bus.alvo_valido = 1'b1;
    cyc();
    bus.alvo_valido = 1'b0;
    repeat (4) cyc();
    check("pre_rst_girar", bus.girar, 1);
    check("pre_rst_giros", bus.giros_feitos, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_girar",   bus.girar, 0);
    check("async_rst_ocupado", bus.ocupado, 0);
    check("async_rst_giros",   bus.giros_feitos, 0);
    check("async_rst_pronto",  bus.alvo_pronto, 1);
    @(posedge clk);
    #1;
    check("held_rst_girar", bus.girar, 0);
    rst_n = 1'b1;
    $display("[TB] mid-turn reset: girar=%b ocupado=%b giros=%0d", bus.girar, bus.ocupado, bus.giros_feitos);
    cyc();
    check("post_rst_girar",   bus.girar, 0);
    check("post_rst_ocupado", bus.ocupado, 0);
    cyc();
    check("post_rst_girar2",  bus.girar, 0);

    do_req(HO, HN, 1'b0, 0);      // recovery after reset

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
